exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 149 ++++++++++++++
 tb/tb_exec_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops and compares, bit-serial shifts,
// valid/ready handshake on both sides, flush and asynchronous reset.
module exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_mode,
    input  logic [1:0]      eval_mode,
    input  logic            sign_ext,
    input  logic [1:0]      in1_sel,
    input  logic [1:0]      in2_sel,
    input  logic            out_sel,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            eval_out,
    output logic            busy
);
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_OR  = 3'd3,
                           ALU_AND = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SRA = 3'd7;
    localparam logic [1:0] EVAL_EQ = 2'd0, EVAL_NEQ = 2'd1, EVAL_LT = 2'd2, EVAL_GE = 2'd3;
    localparam logic [1:0] ALU_IN1_RS1 = 2'd0, ALU_IN1_PC  = 2'd1, ALU_IN1_0 = 2'd2;
    localparam logic [1:0] ALU_IN2_RS2 = 2'd0, ALU_IN2_IMM = 2'd1, ALU_IN2_4 = 2'd2;
    localparam logic       ALU_OUT_EVAL = 1'b1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [4:0]      cnt;
    logic [XLEN-1:0] shreg;
    logic [2:0]      sh_op;
    logic            sh_sel_eval;
    logic            sh_eval;

    logic [XLEN-1:0] op_a, op_b, alu_val, imm_res, sh_next;
    logic [XLEN:0]   a_ext, b_ext, diff;
    logic            eq, lt, eval, is_shift, accept;
    logic [4:0]      shamt;

    assign in_ready = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign shamt    = op_b[4:0];

    always_comb begin
        case (in1_sel)
            ALU_IN1_RS1: op_a = rs1_val;
            ALU_IN1_PC:  op_a = pc;
            ALU_IN1_0:   op_a = '0;
            default:     op_a = '0;
        endcase
        case (in2_sel)
            ALU_IN2_RS2: op_b = rs2_val;
            ALU_IN2_IMM: op_b = imm;
            ALU_IN2_4:   op_b = XLEN'(4);
            default:     op_b = '0;
        endcase

        // Compares share the subtractor; bit XLEN of the widened difference is the less-than flag
        a_ext = {sign_ext & op_a[XLEN-1], op_a};
        b_ext = {sign_ext & op_b[XLEN-1], op_b};
        diff  = a_ext - b_ext;
        lt    = diff[XLEN];
        eq    = (op_a == op_b);
        case (eval_mode)
            EVAL_EQ:  eval = eq;
            EVAL_NEQ: eval = !eq;
            EVAL_LT:  eval = lt;
            default:  eval = !lt;
        endcase

        is_shift = (alu_mode == ALU_SLL) || (alu_mode == ALU_SRL) || (alu_mode == ALU_SRA);
        case (alu_mode)
            ALU_SUB: alu_val = diff[XLEN-1:0];
            ALU_XOR: alu_val = op_a ^ op_b;
            ALU_OR:  alu_val = op_a | op_b;
            ALU_AND: alu_val = op_a & op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_val = op_a;
            default: alu_val = op_a + op_b;
        endcase
        imm_res = (out_sel == ALU_OUT_EVAL) ? {{(XLEN-1){1'b0}}, eval} : alu_val;

        case (sh_op)
            ALU_SLL: sh_next = shreg << 1;
            ALU_SRL: sh_next = shreg >> 1;
            default: sh_next = {shreg[XLEN-1], shreg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            eval_out    <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
            sh_op       <= ALU_ADD;
            sh_sel_eval <= 1'b0;
            sh_eval     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    shreg <= sh_next;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        eval_out  <= sh_eval;
                        result    <= sh_sel_eval ? {{(XLEN-1){1'b0}}, sh_eval} : sh_next;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_shift && shamt != 5'd0) begin
                            state       <= SHIFT;
                            out_valid   <= 1'b0;
                            cnt         <= shamt;
                            shreg       <= op_a;
                            sh_op       <= alu_mode;
                            sh_sel_eval <= (out_sel == ALU_OUT_EVAL);
                            sh_eval     <= eval;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            eval_out  <= eval;
                            result    <= imm_res;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Randomized and directed bench for exec_stage against an arithmetic reference model.
module tb_exec_stage;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR_ = 3'd2, OR_ = 3'd3,
                           AND_ = 3'd4, SLL = 3'd5, SRL = 3'd6, SRA = 3'd7;
    localparam logic [1:0] EQ = 2'd0, NEQ = 2'd1, LT = 2'd2, GE = 2'd3;
    localparam logic [1:0] I1_RS1 = 2'd0, I1_PC = 2'd1, I1_0 = 2'd2;
    localparam logic [1:0] I2_RS2 = 2'd0, I2_IMM = 2'd1, I2_4 = 2'd2;
    localparam logic       O_ALU = 1'b0, O_EVAL = 1'b1;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  alu_mode = '0;
    logic [1:0]  eval_mode = '0;
    logic        sign_ext = 1'b0;
    logic [1:0]  in1_sel = '0, in2_sel = '0;
    logic        out_sel = 1'b0;
    logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0, pc = '0;
    logic        flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [31:0] result;
    logic        eval_out, busy;

    int n_vec = 0;
    int n_err = 0;

    exec_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_mode(alu_mode), .eval_mode(eval_mode), .sign_ext(sign_ext),
        .in1_sel(in1_sel), .in2_sel(in2_sel), .out_sel(out_sel),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .eval_out(eval_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the selected operands
    task automatic model(input logic [2:0] md, input logic [1:0] em, input logic se,
                         input logic [1:0] s1, input logic [1:0] s2, input logic os,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p,
                         output logic [31:0] res, output logic ev, output int lat);
        logic [31:0] a, b, v;
        logic        is_lt, is_eq;
        int          sh;
        a = (s1 == I1_RS1) ? r1 : (s1 == I1_PC) ? p : 32'd0;
        b = (s2 == I2_RS2) ? r2 : (s2 == I2_IMM) ? im : 32'd4;
        sh = int'(b & 32'h1f);
        is_eq = (a == b);
        is_lt = se ? ($signed(a) < $signed(b)) : (a < b);
        case (em)
            EQ:      ev = is_eq;
            NEQ:     ev = !is_eq;
            LT:      ev = is_lt;
            default: ev = !is_lt;
        endcase
        case (md)
            SUB:     v = a - b;
            XOR_:    v = a ^ b;
            OR_:     v = a | b;
            AND_:    v = a & b;
            SLL:     v = a << sh;
            SRL:     v = a >> sh;
            SRA:     v = $signed(a) >>> sh;
            default: v = a + b;
        endcase
        res = os ? {31'd0, ev} : v;
        lat = (md inside {SLL, SRL, SRA} && sh != 0) ? sh + 1 : 1;
    endtask

    task automatic drive(input logic [2:0] md, input logic [1:0] em, input logic se,
                         input logic [1:0] s1, input logic [1:0] s2, input logic os,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p);
        alu_mode = md; eval_mode = em; sign_ext = se; in1_sel = s1; in2_sel = s2;
        out_sel = os; rs1_val = r1; rs2_val = r2; imm = im; pc = p;
    endtask

    task automatic do_op(input string tag, input logic [2:0] md, input logic [1:0] em,
                         input logic se, input logic [1:0] s1, input logic [1:0] s2,
                         input logic os, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p, input int hold);
        logic [31:0] exp_res;
        logic        exp_ev;
        int          exp_lat, lat;
        model(md, em, se, s1, s2, os, r1, r2, im, p, exp_res, exp_ev, exp_lat);
        @(negedge clk);
        out_ready = 1'b0;
        drive(md, em, se, s1, s2, os, r1, r2, im, p);
        in_valid = 1'b1;
        #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        lat = 1;
        // Garbage on the inputs while shifting must not disturb the operation
        while (!out_valid && lat < 40) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            drive(3'($urandom), 2'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
                  2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, result, exp_res);
        check({tag, ".eval"}, 32'(eval_out), 32'(exp_ev));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_result"}, result, exp_res);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".drain_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.eval_out", 32'(eval_out), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst.in_ready", 32'(in_ready), 32'd1);

        // ADD 5+7, single-cycle with in_ready held high
        @(negedge clk);
        drive(ADD, EQ, 1'b0, I1_RS1, I2_IMM, O_ALU, 32'd5, 32'd0, 32'd7, 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("add.valid", 32'(out_valid), 32'd1);
        check("add.result", result, 32'd12);
        check("add.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check("add.drain", 32'(out_valid), 32'd0);

        do_op("sltu", ADD, LT, 1'b0, I1_RS1, I2_RS2, O_EVAL, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        do_op("slt", ADD, LT, 1'b1, I1_RS1, I2_RS2, O_EVAL, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        do_op("sra4", SRA, EQ, 1'b0, I1_RS1, I2_IMM, O_ALU, 32'h8000_0000, 0, 32'd4, 0, 0);
        do_op("sra0", SRA, EQ, 1'b0, I1_RS1, I2_IMM, O_ALU, 32'h8000_0000, 0, 32'd0, 0, 0);
        do_op("bge", SUB, GE, 1'b1, I1_RS1, I2_RS2, O_ALU, -32'sd3, -32'sd3, 0, 0, 0);
        do_op("bne", SUB, NEQ, 1'b1, I1_RS1, I2_RS2, O_ALU, -32'sd3, -32'sd3, 0, 0, 0);
        do_op("auipc4", ADD, EQ, 1'b0, I1_PC, I2_4, O_ALU, 0, 0, 0, 32'h0000_1000, 1);
        do_op("sll31", SLL, LT, 1'b0, I1_RS1, I2_RS2, O_ALU, 32'h0000_0003, 32'd31, 0, 0, 2);

        // Stall 3 cycles in DONE, then back-to-back accept on the releasing edge
        @(negedge clk);
        drive(XOR_, EQ, 1'b0, I1_RS1, I2_RS2, O_ALU, 32'hF0F0_0000, 32'h0FF0_0000, 0, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall.result", result, 32'hFF00_0000);
            check("stall.in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        drive(ADD, EQ, 1'b0, I1_RS1, I2_RS2, O_ALU, 32'd10, 32'd20, 0, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check("b2b.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b.valid", 32'(out_valid), 32'd1);
        check("b2b.result", result, 32'd30);
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b.drain", 32'(out_valid), 32'd0);

        // Flush in the middle of a long shift
        drive(SLL, EQ, 1'b0, I1_RS1, I2_IMM, O_ALU, 32'd1, 0, 32'd10, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        #1 check("flush.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("flush.no_valid", 32'(seen), 32'd0);

        // Reset in the middle of a shift
        drive(SRL, EQ, 1'b0, I1_RS1, I2_IMM, O_ALU, 32'hFFFF_FFFF, 0, 32'd20, 0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.valid", 32'(out_valid), 32'd0);
        check("rstmid.result", result, 32'd0);
        check("rstmid.eval", 32'(eval_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        #1 check("rstmid.in_ready", 32'(in_ready), 32'd1);

        for (int n = 0; n < 150; n++) begin
            do_op("rand", 3'($urandom), 2'($urandom), 1'($urandom),
                  2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
